// File: rtl/dma_io_responder_if.sv
// dma_io_responder_if: DMA single-transfer bus plus the local byte-stream side of the responder
interface dma_io_responder_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  enable;
    logic                  dir;
    logic                  DACK;
    logic                  IOR_N;
    logic                  IOW_N;
    logic                  EOP_N;
    logic                  DREQ;
    logic [DATA_WIDTH-1:0] DB_in;
    logic [DATA_WIDTH-1:0] DB_out;
    logic                  DB_oe;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  tc;
    logic                  tc_clear;
    logic                  spurious;

    modport slave (
        input  enable, dir, DACK, IOR_N, IOW_N, EOP_N, DB_in, tx_data, tx_valid, rx_ready, tc_clear,
        output DREQ, DB_out, DB_oe, tx_ready, rx_data, rx_valid, tc, spurious
    );

    modport master (
        output enable, dir, DACK, IOR_N, IOW_N, EOP_N, DB_in, tx_data, tx_valid, rx_ready, tc_clear,
        input  DREQ, DB_out, DB_oe, tx_ready, rx_data, rx_valid, tc, spurious
    );
endinterface

// File: rtl/dma_io_responder.sv
// dma_io_responder: DMA-capable I/O device answering DREQ/DACK single transfers from two local FIFOs
module dma_io_responder #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               CLK,
    input  logic               RESET_N,
    dma_io_responder_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [4:0] {
        IDLE = 5'b00001,
        REQ  = 5'b00010,
        ACK  = 5'b00100,
        STRB = 5'b01000,
        REL  = 5'b10000
    } state_t;

    state_t                r_state, w_next;
    logic                  r_dir, r_tc, r_spur;
    logic [DATA_WIDTH-1:0] r_hold, w_hold;
    logic [DATA_WIDTH-1:0] r_ob_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_ib_mem [FIFO_DEPTH];
    logic [AW-1:0]         r_ob_wp, r_ob_rp, r_ib_wp, r_ib_rp;
    logic [AW:0]           r_ob_cnt, r_ib_cnt;
    logic                  w_strb_n, w_svc, w_commit, w_oe;
    logic                  w_ob_push, w_ob_pop, w_ib_push, w_ib_pop;

    assign w_strb_n  = r_dir ? bus.IOW_N : bus.IOR_N;
    assign w_svc     = bus.dir ? (r_ib_cnt != FULL) : (r_ob_cnt != '0);
    assign w_commit  = (r_state == STRB) && (w_strb_n || !bus.DACK);
    assign w_hold    = !bus.IOW_N ? bus.DB_in : r_hold;
    assign w_ob_push = bus.tx_valid && (r_ob_cnt != FULL);
    assign w_ob_pop  = w_commit && !r_dir && (r_ob_cnt != '0);
    assign w_ib_push = w_commit && r_dir && (r_ib_cnt != FULL);
    assign w_ib_pop  = bus.rx_ready && (r_ib_cnt != '0);

    // state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // next-state and bus outputs; a strobe wins over a simultaneous DACK drop in ACK
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.enable && w_svc && !r_tc) w_next = REQ;
            REQ:     w_next = bus.DACK ? ACK : (!bus.enable ? IDLE : REQ);
            ACK:     w_next = !w_strb_n ? STRB : (!bus.DACK ? IDLE : ACK);
            STRB:    w_next = !bus.DACK ? IDLE : (w_strb_n ? REL : STRB);
            REL:     if (!bus.DACK) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_oe         = (r_state == STRB) && !r_dir;
        bus.DREQ     = (r_state == REQ) || (r_state == ACK);
        bus.DB_oe    = w_oe;
        bus.DB_out   = w_oe ? r_ob_mem[r_ob_rp] : '0;
        bus.tx_ready = r_ob_cnt != FULL;
        bus.rx_valid = r_ib_cnt != '0;
        bus.rx_data  = r_ib_mem[r_ib_rp];
        bus.tc       = r_tc;
        bus.spurious = r_spur;
    end

    // direction latch, write holding register and sticky flags (set beats clear)
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dir  <= 1'b0;
            r_hold <= '0;
            r_tc   <= 1'b0;
            r_spur <= 1'b0;
        end else begin
            if (r_state == IDLE) r_dir <= bus.dir;
            if ((r_state == ACK || r_state == STRB) && r_dir && !bus.IOW_N) r_hold <= bus.DB_in;
            r_tc   <= (!bus.EOP_N && bus.DACK) ? 1'b1 : (bus.tc_clear ? 1'b0 : r_tc);
            r_spur <= (bus.DACK && r_state == IDLE) ? 1'b1 : (bus.tc_clear ? 1'b0 : r_spur);
        end
    end

    // FIFO pointers and occupancy for both directions
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_ob_wp  <= '0;
            r_ob_rp  <= '0;
            r_ob_cnt <= '0;
            r_ib_wp  <= '0;
            r_ib_rp  <= '0;
            r_ib_cnt <= '0;
        end else begin
            if (w_ob_push) r_ob_wp <= r_ob_wp + AW'(1);
            if (w_ob_pop)  r_ob_rp <= r_ob_rp + AW'(1);
            if (w_ib_push) r_ib_wp <= r_ib_wp + AW'(1);
            if (w_ib_pop)  r_ib_rp <= r_ib_rp + AW'(1);
            r_ob_cnt <= r_ob_cnt + (AW+1)'(w_ob_push) - (AW+1)'(w_ob_pop);
            r_ib_cnt <= r_ib_cnt + (AW+1)'(w_ib_push) - (AW+1)'(w_ib_pop);
        end
    end

    // FIFO storage, contents need no reset since occupancy gates visibility
    always_ff @(posedge CLK) begin
        if (w_ob_push) r_ob_mem[r_ob_wp] <= bus.tx_data;
        if (w_ib_push) r_ib_mem[r_ib_wp] <= w_hold;
    end
endmodule
